muldiv_unit: RTL
================

# muldiv_unit

Iterative unsigned multiply/divide responder for the MIPS core. It owns the HI/LO register pair and executes `multu`/`divu` over several cycles instead of in one combinational ALU step. The datapath issues a request with operands. The unit raises `busy`, pulses `done` when HI/LO hold the result, and serves `mfhi`/`mflo` reads and `mthi`/`mtlo` writes.

## Interface
Parameters:
- DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  1  0 = multu, 1 = divu; sampled with start.
- a  in  DATA_W  rs operand (multiplicand / dividend).
- b  in  DATA_W  rt operand (multiplier / divisor).
- hi_we  in  1  mthi write enable.
- lo_we  in  1  mtlo write enable.
- wdata  in  DATA_W  mthi/mtlo data.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; HI/LO valid in that cycle.
- dbz  out  1  divide-by-zero flag, valid with done; held until the next accepted start.
- hi  out  DATA_W  HI register (registered output).
- lo  out  DATA_W  LO register (registered output).

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE:**
  - If start=1, latch a, b and op, clear the iteration counter, clear dbz, and go to RUN.
  - Otherwise stay in IDLE.
- **RUN:** perform one iteration per cycle. After DATA_W iterations (counter = DATA_W−1 on the edge), go to DONE and load the result into HI/LO on that same edge.
- **DONE:** assert done=1 for this cycle only, then return to IDLE. start is ignored in DONE.
- **multu:** shift-add, one multiplier bit per cycle, LSB first. Produces a 2·DATA_W product: HI = upper half, LO = lower half. The result is exact; no overflow.
- **divu:** restoring division, one quotient bit per cycle, MSB first. Working remainder is DATA_W+1 bits. LO = quotient, HI = remainder.
- **Divide by zero (b=0):** no special path. The algorithm naturally yields LO = all ones and HI = a. Set dbz=1 at DONE.
- **mthi/mtlo:**
  - Writes take effect on the edge when state = IDLE.
  - Writes are ignored while busy=1.
  - hi_we and lo_we may both be set; each updates its own register from wdata.
- **Write and start in the same cycle:** both take effect. The write lands now; the operation result later overwrites HI/LO.
- **Operand changes while busy:** the unit uses only the latched operands; input changes have no effect.

## Timing
- **Reset values:** state=IDLE, hi=0, lo=0, busy=0, done=0, dbz=0, counter=0.
- **Reset during RUN/DONE:** abort immediately. No HI/LO update and no done pulse.
- **Latency:**
  - start sampled at edge E.
  - busy=1 from E through E+DATA_W+1.
  - done=1 in the cycle after edge E+DATA_W.
  - HI/LO carry the new value during that done cycle.
  - With DATA_W=32, done appears 33 cycles after start.
- **Back-to-back:** the earliest next start is sampled on the edge after the done cycle. That gives a DATA_W+2 cycle issue interval.
- **During an operation:** hi/lo hold their previous values throughout RUN. The datapath must stall mfhi/mflo while busy=1.
- done never asserts without a preceding accepted start.

## Structure
- Package `muldiv_pkg` contains:
  - op encodings: OP_MULTU=1'b0, OP_DIVU=1'b1.
  - FSM state encoding for IDLE/RUN/DONE.
  - default DATA_W constant.
- Sub-module `muldiv_step`: a combinational single-iteration datapath. It takes the accumulator/remainder, the operand register and op, and returns the next accumulator plus the shifted operand or quotient bit. The FSM, counter and HI/LO registers stay in `muldiv_unit`.

## Test plan
- **multu 7 × 6:** start once → done 33 cycles later with hi=0x00000000, lo=0x0000002A, dbz=0.
- **multu 0xFFFFFFFF × 0xFFFFFFFF:** hi=0xFFFFFFFE, lo=0x00000001.
- **divu 100 / 7:** lo=0x0000000E, hi=0x00000002.
- **divu 0x80000000 / 0x00000003:** lo=0x2AAAAAAA, hi=0x00000002.
- **divu 5 / 0:** lo=0xFFFFFFFF, hi=0x00000005, dbz=1 during done and held afterwards.
- **Protocol checks:**
  - Pulse start with a different operand pair during RUN → request ignored; the result matches the first request.
  - Assert hi_we with wdata=0x12345678 while busy → hi unchanged.
  - Same write in IDLE → hi=0x12345678 next cycle.
  - Assert reset at iteration 10 → busy=0, hi=lo=0, and no done pulse on later cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM state type and the default datapath width.
package muldiv_pkg;

  localparam int DATA_W_DEFAULT = 32;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of shift-add multiply (LSB first) or
// restoring divide (MSB first, one quotient bit per call).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              i_op,
  input  logic [DATA_W:0]   i_acc,
  input  logic [DATA_W-1:0] i_opnd,
  input  logic [DATA_W-1:0] i_oper,
  output logic [DATA_W:0]   o_acc,
  output logic [DATA_W-1:0] o_opnd
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_shift;
  logic [DATA_W+1:0] w_diff;

  // i_opnd holds the multiplier (multu) or dividend/quotient (divu);
  // i_oper is the multiplicand or divisor.
  always_comb begin
    w_sum   = i_acc + (i_opnd[0] ? {1'b0, i_oper} : '0);
    w_shift = {i_acc[DATA_W-1:0], i_opnd[DATA_W-1]};
    w_diff  = {1'b0, w_shift} - {2'b00, i_oper};
    o_acc   = {1'b0, w_sum[DATA_W:1]};
    o_opnd  = {w_sum[0], i_opnd[DATA_W-1:1]};
    if (i_op == OP_DIVU) begin
      if (!w_diff[DATA_W+1]) begin
        o_acc  = w_diff[DATA_W:0];
        o_opnd = {i_opnd[DATA_W-2:0], 1'b1};
      end else begin
        o_acc  = w_shift;
        o_opnd = {i_opnd[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO owner for multu/divu: an IDLE/RUN/DONE FSM drives one
// muldiv_step iteration per cycle and serves mthi/mtlo writes.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              dbz,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_op;
  logic [DATA_W:0]   r_acc;
  logic [DATA_W-1:0] r_opnd;
  logic [DATA_W-1:0] r_oper;
  logic              r_busy;
  logic              r_done;
  logic              r_dbz;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  logic [DATA_W:0]   w_acc;
  logic [DATA_W-1:0] w_opnd;

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .i_op   (r_op),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .i_oper (r_oper),
    .o_acc  (w_acc),
    .o_opnd (w_opnd)
  );

  // Both algorithms leave the high half / remainder in the accumulator
  // and the low half / quotient in the shifting operand register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_MULTU;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_oper  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            r_op    <= op;
            r_opnd  <= (op == OP_MULTU) ? b : a;
            r_oper  <= (op == OP_MULTU) ? a : b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_dbz   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_acc  <= w_acc;
          r_opnd <= w_opnd;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_hi    <= w_acc[DATA_W-1:0];
            r_lo    <= w_opnd;
            r_dbz   <= (r_op == OP_DIVU) && (r_oper == '0);
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dbz  = r_dbz;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
